// File: rtl/store_path_ctrl.sv
// Buffered store unit: in-order store FIFO, byte-lane shifting, region decode,
// misaligned-store splitting and a valid/ready UART TX port.
module store_path_ctrl #(
  parameter int unsigned BUF_DEPTH    = 4,
  parameter bit          SPLIT_MISAL  = 1'b1,
  parameter logic [31:0] UART_TX_ADDR = 32'h8000_0008,
  parameter logic [31:0] CNT_RST_ADDR = 32'h8000_0018,
  parameter logic [31:0] LED_ADDR     = 32'h8000_0030
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_funct3,
  input  logic        st_imem_ok,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  dmem_wea,
  output logic [3:0]  imem_wea,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        counter_reset,
  output logic        leds_we,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, SPLIT, UART_WAIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  funct3;
    logic        imem_ok;
  } entry_t;

  entry_t        fifo_q [BUF_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, empty;
  entry_t        head;

  state_t        state_q, state_d;

  logic [31:0]   addr_d, wdata_d;
  logic [3:0]    dwea_d, iwea_d;
  logic          txv_d, crst_d, led_d, err_d;
  logic [7:0]    txd_d;

  logic          spl_pend_q, spl_pend_d;
  logic [31:0]   spl_addr_q, spl_addr_d;
  logic [31:0]   spl_data_q, spl_data_d;
  logic [3:0]    spl_wea_q, spl_wea_d;
  logic          spl_ok_q, spl_ok_d;

  logic [1:0]    hd_off;
  logic [31:0]   hd_word;
  logic          hd_illegal;
  logic [31:0]   hd_dmask;
  logic [3:0]    hd_bmask;
  logic [63:0]   hd_lanes;
  logic [7:0]    hd_wea8;
  logic          hd_misal;
  logic [3:0]    hd_region;

  function automatic logic is_mem(input logic [3:0] region);
    return (region == 4'h1) || (region == 4'h2) || (region == 4'h3);
  endfunction

  // Returns {imem_wea, dmem_wea} for a memory-region beat.
  function automatic logic [7:0] mem_strobes(input logic [3:0] region,
                                             input logic       ok,
                                             input logic [3:0] wea);
    logic [3:0] d, i;
    d = '0;
    i = '0;
    case (region)
      4'h1: d = wea;
      4'h2: if (ok) i = wea;
      4'h3: begin
        d = wea;
        if (ok) i = wea;
      end
      default: ;
    endcase
    return {i, d};
  endfunction

  assign push  = st_valid && st_ready;
  assign empty = (count_q == '0);
  assign head  = fifo_q[rptr_q];

  // FIFO occupancy after this edge; drives registered st_ready and busy.
  always_comb begin
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= '{addr: st_addr, data: st_data,
                                  funct3: st_funct3, imem_ok: st_imem_ok};
  end

  // FIFO pointers, occupancy, st_ready and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      st_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q  <= count_d;
      st_ready <= (count_d != (AW+1)'(BUF_DEPTH));
      busy     <= (count_d != '0) || (state_d != IDLE);
    end
  end

  // Lane placement of the FIFO head; the upper word of hd_lanes/hd_wea8 is the spill beat.
  always_comb begin
    hd_off     = head.addr[1:0];
    hd_word    = {head.addr[31:2], 2'b00};
    hd_region  = head.addr[31:28];
    hd_illegal = (head.funct3 > 3'd2);
    case (head.funct3[1:0])
      2'd0:    begin hd_dmask = 32'h0000_00FF; hd_bmask = 4'b0001; end
      2'd1:    begin hd_dmask = 32'h0000_FFFF; hd_bmask = 4'b0011; end
      default: begin hd_dmask = 32'hFFFF_FFFF; hd_bmask = 4'b1111; end
    endcase
    hd_lanes = {32'h0, head.data & hd_dmask} << {hd_off, 3'b000};
    hd_wea8  = {4'h0, hd_bmask} << hd_off;
    hd_misal = |hd_wea8[7:4];
  end

  // Next state and next registered outputs; outputs reflect the beat being presented.
  always_comb begin
    state_d    = IDLE;
    pop        = 1'b0;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    dwea_d     = '0;
    iwea_d     = '0;
    txv_d      = 1'b0;
    txd_d      = uart_tx_data;
    crst_d     = 1'b0;
    led_d      = 1'b0;
    err_d      = 1'b0;
    spl_pend_d = 1'b0;
    spl_addr_d = spl_addr_q;
    spl_data_d = spl_data_q;
    spl_wea_d  = spl_wea_q;
    spl_ok_d   = spl_ok_q;

    if (state_q == UART_WAIT && !uart_tx_ready) begin
      state_d = UART_WAIT;
      txv_d   = 1'b1;
    end else if (spl_pend_q) begin
      // Second beat is decoded on its own address, so it may land in another region.
      state_d = SPLIT;
      addr_d  = spl_addr_q;
      wdata_d = spl_data_q;
      {iwea_d, dwea_d} = mem_strobes(spl_addr_q[31:28], spl_ok_q, spl_wea_q);
    end else if (!empty) begin
      pop     = 1'b1;
      state_d = ISSUE;
      if (hd_illegal) begin
        err_d = 1'b1;
      end else if (is_mem(hd_region)) begin
        if (hd_misal && !SPLIT_MISAL) begin
          err_d = 1'b1;
        end else begin
          addr_d  = hd_word;
          wdata_d = hd_lanes[31:0];
          {iwea_d, dwea_d} = mem_strobes(hd_region, head.imem_ok, hd_wea8[3:0]);
          if (hd_misal) begin
            spl_pend_d = 1'b1;
            spl_addr_d = hd_word + 32'd4;
            spl_data_d = hd_lanes[63:32];
            spl_wea_d  = hd_wea8[7:4];
            spl_ok_d   = head.imem_ok;
          end
        end
      end else if (hd_region == 4'h8) begin
        if (hd_misal) begin
          err_d = 1'b1;
        end else if (head.addr == UART_TX_ADDR) begin
          state_d = UART_WAIT;
          txv_d   = 1'b1;
          txd_d   = head.data[7:0];
        end else if (head.addr == CNT_RST_ADDR) begin
          crst_d = 1'b1;
        end else if (head.addr == LED_ADDR) begin
          led_d   = 1'b1;
          addr_d  = hd_word;
          wdata_d = hd_lanes[31:0];
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      dmem_wea      <= '0;
      imem_wea      <= '0;
      uart_tx_valid <= 1'b0;
      uart_tx_data  <= '0;
      counter_reset <= 1'b0;
      leds_we       <= 1'b0;
      err           <= 1'b0;
      spl_pend_q    <= 1'b0;
      spl_addr_q    <= '0;
      spl_data_q    <= '0;
      spl_wea_q     <= '0;
      spl_ok_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_addr      <= addr_d;
      mem_wdata     <= wdata_d;
      dmem_wea      <= dwea_d;
      imem_wea      <= iwea_d;
      uart_tx_valid <= txv_d;
      uart_tx_data  <= txd_d;
      counter_reset <= crst_d;
      leds_we       <= led_d;
      err           <= err_d;
      spl_pend_q    <= spl_pend_d;
      spl_addr_q    <= spl_addr_d;
      spl_data_q    <= spl_data_d;
      spl_wea_q     <= spl_wea_d;
      spl_ok_q      <= spl_ok_d;
    end
  end

endmodule
